// File: rtl/divider_control_array.sv
// Shares one pipelined single-precision divide core across CH channels; ena_math is the global
// math clock enable. Define DIV_ZERO_DET_EN to flag and patch divide-by-zero results.
module divider_control_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH    = 4,
  parameter int unsigned LAT   = 6,
  parameter int unsigned IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_math,
  input  logic                  sta,
  input  logic [CH*WIDTH-1:0]   x,
  input  logic [CH*WIDTH-1:0]   y,
  output logic [CH*WIDTH-1:0]   xy,
  output logic                  busy,
  output logic                  done_sig,
  output logic [CH-1:0]         dz_flag
);

  localparam int unsigned CntW = IDXW + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(CH - 1);
  localparam logic [CntW-1:0] ChCnt   = CntW'(CH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  // Divide_nodsp behaviour: round-to-nearest-even on normals, denormals flushed to zero.
  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [7:0]        ea, eb;
    logic [49:0]       num, den;
    logic [26:0]       quo;
    logic [23:0]       rem, mant;
    logic              rnd, stk;
    logic [24:0]       mant_r;
    logic signed [10:0] e;
    logic [31:0]       res;
    sgn = a[31] ^ b[31];
    ea  = a[30:23];
    eb  = b[30:23];
    num = {1'b1, a[22:0], 26'd0};
    den = {26'd0, 1'b1, b[22:0]};
    quo = 27'(num / den);
    rem = 24'(num % den);
    e   = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd127;
    if (quo[26]) begin
      mant = quo[26:3];
      rnd  = quo[2];
      stk  = (|quo[1:0]) | (|rem);
    end else begin
      mant = quo[25:2];
      rnd  = quo[1];
      stk  = quo[0] | (|rem);
      e    = e - 11'sd1;
    end
    mant_r = {1'b0, mant} + {24'd0, rnd & (stk | mant[0])};
    if (mant_r[24]) e = e + 11'sd1;
    res = {sgn, e[7:0], mant_r[24] ? 23'd0 : mant_r[22:0]};
    if (e >= 11'sd255) res = {sgn, 8'hFF, 23'd0};
    else if (e <= 11'sd0) res = {sgn, 31'd0};
    if (ea == 8'hFF || eb == 8'hFF) res = 32'h7FC0_0000;
    else if (eb == 8'd0) res = (ea == 8'd0) ? 32'h7FC0_0000 : {sgn, 8'hFF, 23'd0};
    else if (ea == 8'd0) res = {sgn, 31'd0};
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [CH*WIDTH-1:0]   x_q, y_q;
  logic [CntW-1:0]       issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
  logic                  pipe_vld_q [LAT];
  logic [IDXW-1:0]       pipe_idx_q [LAT];
  logic [WIDTH-1:0]      pipe_dat_q [LAT];
  logic [WIDTH-1:0]      shadow_q   [CH];
  logic [CH*WIDTH-1:0]   shadow_flat;
  logic [CH*WIDTH-1:0]   xy_q;
  logic                  busy_q, done_q;
  logic                  accept, issue_fire, ret, collect;
  logic [IDXW-1:0]       issue_idx, ret_idx;
  logic [WIDTH-1:0]      x_sel, y_sel, core_res, ret_val;

  assign issue_idx  = issue_cnt_q[IDXW-1:0];
  assign issue_fire = (state_q == StIssue);
  assign x_sel      = x_q[32'(issue_idx) * WIDTH +: WIDTH];
  assign y_sel      = y_q[32'(issue_idx) * WIDTH +: WIDTH];
  assign core_res   = fp_div(x_sel, y_sel);
  assign ret        = pipe_vld_q[LAT-1];
  assign ret_idx    = pipe_idx_q[LAT-1];
  // Returns can land while still issuing when CH > LAT.
  assign collect    = ret && (state_q == StIssue || state_q == StDrain);

`ifdef DIV_ZERO_DET_EN
  logic [CH-1:0]    dz_sh_q, dz_q;
  logic [WIDTH-1:0] ret_x, ret_y;

  assign ret_x = x_q[32'(ret_idx) * WIDTH +: WIDTH];
  assign ret_y = y_q[32'(ret_idx) * WIDTH +: WIDTH];

  always_comb begin
    ret_val = pipe_dat_q[LAT-1];
    if (dz_sh_q[ret_idx]) begin
      ret_val = (ret_x[30:0] == 31'd0) ? 32'h7FC0_0000 : {ret_x[31] ^ ret_y[31], 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dz_sh_q <= '0;
      dz_q    <= '0;
    end else if (ena_math) begin
      if (accept) dz_sh_q <= '0;
      else if (issue_fire && y_sel[30:0] == 31'd0) dz_sh_q[issue_idx] <= 1'b1;
      if (state_q == StDone) dz_q <= dz_sh_q;
    end
  end

  assign dz_flag = dz_q;
`else
  assign ret_val = pipe_dat_q[LAT-1];
  assign dz_flag = '0;
`endif

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    accept      = 1'b0;
    if (collect) ret_cnt_d = ret_cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (sta) begin
          accept      = 1'b1;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LastIdx) state_d = StDrain;
      end
      StDrain: begin
        if (ret_cnt_d == ChCnt) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < int'(CH); i++) shadow_flat[i*WIDTH +: WIDTH] = shadow_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      xy_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(LAT); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= '0;
        pipe_dat_q[i] <= '0;
      end
      for (int i = 0; i < int'(CH); i++) shadow_q[i] <= '0;
    end else if (ena_math) begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      if (accept) begin
        x_q <= x;
        y_q <= y;
      end
      if (accept)      busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;
      pipe_vld_q[0] <= issue_fire;
      pipe_idx_q[0] <= issue_idx;
      pipe_dat_q[0] <= core_res;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
      if (collect) shadow_q[ret_idx] <= ret_val;
      done_q <= (state_q == StDone);
      if (state_q == StDone) xy_q <= shadow_flat;
    end
  end

  assign xy       = xy_q;
  assign busy     = busy_q;
  assign done_sig = done_q;

endmodule

// File: tb/tb_divider_control_array.sv
// Bench for divider_control_array: directed scenarios plus random jobs against a real-arithmetic model.
module tb_divider_control_array;
  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int LAT = 6;
  localparam int N   = CH * W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena_math = 1'b1;
  logic         sta = 1'b0;
  logic [N-1:0] x = '0, y = '0;
  logic [N-1:0] xy;
  logic         busy, done_sig;
  logic [CH-1:0] dz_flag;

  int checks = 0;
  int failures = 0;

  divider_control_array #(.WIDTH(W), .CH(CH), .LAT(LAT), .IDXW(2)) dut (
    .clk(clk), .rst(rst), .ena_math(ena_math), .sta(sta), .x(x), .y(y),
    .xy(xy), .busy(busy), .done_sig(done_sig), .dz_flag(dz_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] s2d(input logic [31:0] f);
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [52:0] m;
    logic [24:0] k;
    int          e;
    m = {1'b1, d[51:0]};
    k = {1'b0, m[52:29]} + 25'(m[28] && ((|m[27:0]) || m[29]));
    e = int'(d[62:52]) - 896;
    if (k[24]) begin
      e++;
      k = k >> 1;
    end
    return {d[63], 8'(e), k[22:0]};
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    real q;
    if (b[30:0] == 31'd0) return (a[30:0] == 31'd0) ? 32'h7FC0_0000 : {a[31] ^ b[31], 8'hFF, 23'd0};
    if (a[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    q = $bitstoreal(s2d(a)) / $bitstoreal(s2d(b));
    return d2s($realtobits(q));
  endfunction

  function automatic logic [N-1:0] ref_bank(input logic [N-1:0] xv, input logic [N-1:0] yv);
    logic [N-1:0] r;
    for (int c = 0; c < CH; c++) r[c*W +: W] = ref_div(xv[c*W +: W], yv[c*W +: W]);
    return r;
  endfunction

  function automatic logic [CH-1:0] ref_dz(input logic [N-1:0] yv);
    logic [CH-1:0] r;
    r = '0;
`ifdef DIV_ZERO_DET_EN
    for (int c = 0; c < CH; c++) r[c] = (yv[c*W +: 31] == 31'd0);
`endif
    return r;
  endfunction

  function automatic logic [31:0] rnd_float();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  // Pulses sta, scrambles inputs afterwards, optionally pulses sta again and stalls ena_math.
  task automatic run_job(input logic [N-1:0] xv, input logic [N-1:0] yv, input int sta2_at,
                         input int stall_at, input int stall_len, output int lat,
                         output bit changed, output bit busy_ok);
    logic [N-1:0] prev;
    int cyc;
    @(negedge clk);
    x = xv; y = yv; sta = 1'b1;
    @(negedge clk);
    sta = 1'b0;
    for (int c = 0; c < CH; c++) begin
      x[c*W +: W] = $urandom;
      y[c*W +: W] = $urandom;
    end
    cyc = 0; lat = -1; changed = 0; busy_ok = 1; prev = xy;
    while (cyc < 100 && lat < 0) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      sta = (cyc == sta2_at);
      ena_math = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (!busy) busy_ok = 0;
      if (done_sig) lat = cyc;
      else if (xy !== prev) changed = 1;
    end
    sta = 1'b0;
    ena_math = 1'b1;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_sig) cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt, lat;
    bit ch, bo;
    #3;
    checks++;
    if (busy !== 1'b0 || done_sig !== 1'b0 || xy !== '0 || dz_flag !== '0) begin
      failures++;
      $display("FAIL reset_init: busy=%b done=%b xy=%h dz=%b, want 0", busy, done_sig, xy, dz_flag);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    x = {CH{32'h3F80_0000}}; y = {CH{32'h4000_0000}}; sta = 1'b1;
    @(negedge clk);
    sta = 1'b0;
    @(negedge clk);
    sta = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done_sig !== 1'b0 || xy !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b xy=%h, want 0", busy, done_sig, xy);
    end
    @(negedge clk);
    sta = 1'b0;
    rst = 1'b1;
    count_done(25, cnt);
    checks++;
    if (cnt !== 0 || xy !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_after: done_pulses=%0d xy=%h busy=%b, want 0", cnt, xy, busy);
    end
    lat = 0; ch = 0; bo = 0;
  endtask

  task automatic test_basic();
    logic [N-1:0] xv, yv;
    int lat, cnt;
    bit ch, bo;
    xv = {32'h40C0_0000, 32'h3F80_0000, 32'hC120_0000, 32'h4000_0000};
    yv = {32'h4000_0000, 32'h4080_0000, 32'h4000_0000, 32'h3F00_0000};
    run_job(xv, yv, -1, -1, 0, lat, ch, bo);
    checks++;
    if (lat !== 11) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 11", lat);
    end
    checks++;
    if (xy !== {32'h4040_0000, 32'h3E80_0000, 32'hC0A0_0000, 32'h4080_0000}) begin
      failures++;
      $display("FAIL basic_xy: got %h want 40400000_3e800000_c0a00000_40800000", xy);
    end
    checks++;
    if (ch || !bo) begin
      failures++;
      $display("FAIL basic_stable_busy: xy_changed=%b busy_ok=%b want 0/1", ch, bo);
    end
    count_done(1, cnt);
    checks++;
    if (done_sig !== 1'b0 || busy !== 1'b0 || cnt !== 0) begin
      failures++;
      $display("FAIL basic_pulse: done=%b busy=%b want 0/0", done_sig, busy);
    end
  endtask

  task automatic test_busy_guard();
    logic [N-1:0] xv, yv;
    int lat, cnt;
    bit ch, bo;
    for (int c = 0; c < CH; c++) begin
      xv[c*W +: W] = rnd_float();
      yv[c*W +: W] = rnd_float();
    end
    run_job(xv, yv, 3, -1, 0, lat, ch, bo);
    checks++;
    if (lat !== 11 || xy !== ref_bank(xv, yv)) begin
      failures++;
      $display("FAIL busy_guard: lat=%0d xy=%h want 11 %h", lat, xy, ref_bank(xv, yv));
    end
    count_done(20, cnt);
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL busy_guard_extra: done_pulses=%0d want 0", cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] xa, ya, xb, yb, ea, eb;
    int cyc, d1, d2;
    bit stable_ok, busy_ok;
    for (int c = 0; c < CH; c++) begin
      xa[c*W +: W] = rnd_float(); ya[c*W +: W] = rnd_float();
      xb[c*W +: W] = rnd_float(); yb[c*W +: W] = rnd_float();
    end
    ea = ref_bank(xa, ya);
    eb = ref_bank(xb, yb);
    @(negedge clk);
    x = xa; y = ya; sta = 1'b1;
    @(negedge clk);
    x = xb; y = yb;
    cyc = 0; d1 = -1; d2 = -1; stable_ok = 1; busy_ok = 1;
    while (cyc < 100 && d2 < 0) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!busy) busy_ok = 0;
      if (done_sig && d1 < 0) begin
        d1 = cyc;
        checks++;
        if (xy !== ea) begin
          failures++;
          $display("FAIL b2b_job1: got %h want %h", xy, ea);
        end
      end else if (done_sig) begin
        d2 = cyc;
        sta = 1'b0;
      end else if (d1 > 0 && xy !== ea) stable_ok = 0;
    end
    sta = 1'b0;
    checks++;
    if (d1 !== 11 || d2 - d1 !== 12) begin
      failures++;
      $display("FAIL b2b_timing: done1=%0d done2=%0d want 11 23", d1, d2);
    end
    checks++;
    if (xy !== eb || !stable_ok || !busy_ok) begin
      failures++;
      $display("FAIL b2b_job2: xy=%h stable=%b busy=%b want %h 1 1", xy, stable_ok, busy_ok, eb);
    end
    @(negedge clk);
  endtask

  task automatic test_enable_stall();
    logic [N-1:0] xv, yv;
    int lat;
    bit ch, bo;
    for (int c = 0; c < CH; c++) begin
      xv[c*W +: W] = rnd_float();
      yv[c*W +: W] = rnd_float();
    end
    run_job(xv, yv, -1, 7, 5, lat, ch, bo);
    checks++;
    if (lat !== 16 || xy !== ref_bank(xv, yv) || ch) begin
      failures++;
      $display("FAIL enable_stall: lat=%0d xy=%h chg=%b want 16 %h 0", lat, xy, ch,
               ref_bank(xv, yv));
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] xv, yv;
    int lat;
    bit ch, bo;
    xv = {32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
    yv = {32'h4000_0000, 32'h4080_0000, 32'h0000_0000, 32'h3F00_0000};
    run_job(xv, yv, -1, -1, 0, lat, ch, bo);
    checks++;
    if (xy[W +: W] !== 32'hFF80_0000 || xy !== ref_bank(xv, yv) || dz_flag !== ref_dz(yv)) begin
      failures++;
      $display("FAIL div_zero_ch1: xy=%h dz=%b want ch1 ff800000 dz %b", xy, dz_flag, ref_dz(yv));
    end
    xv[W-1:0] = 32'h8000_0000;
    yv[W-1:0] = 32'h0000_0000;
    run_job(xv, yv, -1, -1, 0, lat, ch, bo);
    checks++;
    if (xy[W-1:0] !== 32'h7FC0_0000 || xy !== ref_bank(xv, yv) || dz_flag !== ref_dz(yv)) begin
      failures++;
      $display("FAIL div_zero_ch0: xy=%h dz=%b want ch0 7fc00000 dz %b", xy, dz_flag, ref_dz(yv));
    end
  endtask

  task automatic test_random();
    logic [N-1:0] xv, yv;
    int lat, cnt;
    bit ch, bo;
    for (int j = 0; j < 16; j++) begin
      for (int c = 0; c < CH; c++) begin
        xv[c*W +: W] = ($urandom_range(7) == 0) ? {1'($urandom), 31'd0} : rnd_float();
        yv[c*W +: W] = ($urandom_range(7) == 0) ? {1'($urandom), 31'd0} : rnd_float();
      end
      run_job(xv, yv, -1, -1, 0, lat, ch, bo);
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (xy[c*W +: W] !== ref_div(xv[c*W +: W], yv[c*W +: W])) begin
          failures++;
          $display("FAIL random_xy job%0d ch%0d: got %h want %h (x=%h y=%h)", j, c,
                   xy[c*W +: W], ref_div(xv[c*W +: W], yv[c*W +: W]), xv[c*W +: W],
                   yv[c*W +: W]);
        end
      end
      checks++;
      if (lat !== 11 || dz_flag !== ref_dz(yv) || ch || !bo) begin
        failures++;
        $display("FAIL random_ctl job%0d: lat=%0d dz=%b chg=%b busy=%b want 11 %b 0 1", j, lat,
                 dz_flag, ch, bo, ref_dz(yv));
      end
      count_done($urandom_range(3, 1), cnt);
      checks++;
      if (cnt !== 0) begin
        failures++;
        $display("FAIL random_idle job%0d: done_pulses=%0d want 0", j, cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_guard();
    test_back_to_back();
    test_enable_stall();
    test_div_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
